axi_slave_read_fifo: RTL



---
 rtl/ip_axi_pkg.sv | 18 +
 rtl/axi_rd_skid_buf.sv | 42 ++++
 rtl/axi_slave_read_fifo.sv | 121 ++++++++++++
 3 files changed

// File: rtl/ip_axi_pkg.sv
// Shared AXI slave constants: response codes, read-path state encodings and
// the AxSIZE decode helper.
package ip_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    RD_IDLE = 2'b00,
    RD_REQ  = 2'b01,
    RD_DATA = 2'b10
  } rd_state_t;

  function automatic logic [7:0] size_to_bytes(input logic [2:0] size);
    return 8'd1 << size;
  endfunction

endpackage

// File: rtl/axi_rd_skid_buf.sv
// Two-entry first-word-fall-through buffer holding {rdata, rresp, rlast}.
// A push into an empty buffer is visible at the head in the same cycle.
module axi_rd_skid_buf #(
  parameter int unsigned WIDTH = 67
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             bypass;

  // Empty buffer pushed and popped together: the beat never lands in storage.
  assign bypass     = push && pop && (count == 2'd0);
  assign head_valid = (count != 2'd0) || push;
  assign head_data  = (count != 2'd0) ? mem[rd_ptr] : push_data;

  always_ff @(posedge clock) begin
    if (push && !bypass) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push && !bypass) wr_ptr <= ~wr_ptr;
      if (pop && (count != 2'd0)) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/axi_slave_read_fifo.sv
// AXI4 read-channel responder: one AR burst at a time, beats popped from the
// FIFO read port and returned on R through a two-entry skid buffer.
module axi_slave_read_fifo
  import ip_axi_pkg::*;
#(
  parameter int unsigned UNIQUE_ID_SZ    = 3,
  parameter int unsigned ADDR_WIDTH      = 64,
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned FIFO_ADDR_SHIFT = 7,
  parameter int unsigned FIFO_ADDR_WIDTH = 25,
  parameter int unsigned MEM_ADDR_SHIFT  = 7,
  parameter int unsigned MEM_ADDR_WIDTH  = 25
) (
  input  logic                       clock,
  input  logic                       reset,
  output logic                       arready,
  input  logic                       arvalid,
  input  logic [ADDR_WIDTH-1:0]      araddr,
  input  logic [7:0]                 arlen,
  input  logic [2:0]                 arsize,
  input  logic [UNIQUE_ID_SZ-1:0]    arid,
  output logic                       rvalid,
  input  logic                       rready,
  output logic [DATA_WIDTH-1:0]      rdata,
  output logic [1:0]                 rresp,
  output logic                       rlast,
  output logic [UNIQUE_ID_SZ-1:0]    rid,
  input  logic                       fifo_empty,
  input  logic                       fifo_underflow,
  input  logic [DATA_WIDTH-1:0]      data_from_fifo,
  output logic                       fifo_pop,
  output logic [FIFO_ADDR_WIDTH-1:0] read_addr,
  output logic [MEM_ADDR_WIDTH-1:0]  read_addr_mem,
  output logic [12:0]                read_byte_sz,
  output logic                       read_req
);

  localparam int unsigned BUF_W = DATA_WIDTH + 3;

  rd_state_t        state;
  logic [8:0]       pop_cnt;
  logic [8:0]       beat_cnt;
  logic             pop_d;
  logic             pop_last_d;
  logic             r_hs;
  logic             buf_valid;
  logic [1:0]       buf_count;
  logic [BUF_W-1:0] buf_in;
  logic [BUF_W-1:0] buf_head;

  assign arready  = (state == RD_IDLE);
  assign read_req = (state == RD_REQ);
  assign r_hs     = buf_valid && rready;
  assign rvalid   = buf_valid;

  // Credit: beats held in the buffer plus the one still in flight from the FIFO.
  assign fifo_pop = (state == RD_DATA) && (pop_cnt != 9'd0) && !fifo_empty &&
                    (({1'b0, buf_count} + {2'b00, pop_d}) < 3'd2);

  assign buf_in = {data_from_fifo, fifo_underflow ? RESP_DECERR : RESP_OKAY, pop_last_d};

  always_comb begin
    {rdata, rresp, rlast} = buf_valid ? buf_head : '0;
  end

  axi_rd_skid_buf #(
    .WIDTH(BUF_W)
  ) u_skid (
    .clock     (clock),
    .reset     (reset),
    .push      (pop_d),
    .push_data (buf_in),
    .pop       (r_hs),
    .head_data (buf_head),
    .head_valid(buf_valid),
    .count     (buf_count)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= RD_IDLE;
      pop_cnt       <= '0;
      beat_cnt      <= '0;
      rid           <= '0;
      read_addr     <= '0;
      read_addr_mem <= '0;
      read_byte_sz  <= '0;
      pop_d         <= 1'b0;
      pop_last_d    <= 1'b0;
    end else begin
      pop_d      <= fifo_pop;
      pop_last_d <= fifo_pop && (pop_cnt == 9'd1);
      case (state)
        RD_IDLE: begin
          if (arvalid) begin
            rid           <= arid;
            pop_cnt       <= {1'b0, arlen} + 9'd1;
            beat_cnt      <= {1'b0, arlen} + 9'd1;
            read_addr     <= FIFO_ADDR_WIDTH'(araddr >> FIFO_ADDR_SHIFT);
            read_addr_mem <= MEM_ADDR_WIDTH'(araddr >> MEM_ADDR_SHIFT);
            read_byte_sz  <= ({5'd0, arlen} + 13'd1) * {5'd0, size_to_bytes(arsize)};
            state         <= RD_REQ;
          end
        end
        RD_REQ: state <= RD_DATA;
        RD_DATA: begin
          if (fifo_pop) begin
            pop_cnt       <= pop_cnt - 9'd1;
            read_addr_mem <= read_addr_mem + MEM_ADDR_WIDTH'(1);
          end
          if (r_hs) begin
            beat_cnt <= beat_cnt - 9'd1;
            if (beat_cnt == 9'd1) state <= RD_IDLE;
          end
        end
        default: state <= RD_IDLE;
      endcase
    end
  end

endmodule
